// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Optional feature macro used by seq_mult_n: SEQ_MULT_SIGNED_EN.
package mult_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mult_state_e;

    // Bits needed for a counter that steps 0 .. w-1 (never narrower than 1).
    function automatic int count_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_mult_n.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product in a fixed
// WIDTH-cycle run, one multiplier bit per cycle, LSB first.
// Define SEQ_MULT_SIGNED_EN to add the is_signed port and two's-complement mode.
module seq_mult_n
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                 is_signed,
`endif
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = count_width(WIDTH);

    mult_state_e          r_state;
    mult_state_e          w_state_next;
    logic [2*WIDTH-1:0]   r_acc;      // {partial sum, remaining multiplier bits}
    logic [WIDTH-1:0]     r_mcand;
    logic [CW-1:0]        r_count;
    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_result;

    assign w_accept = start && ready;
    assign w_last   = (r_count == CW'(WIDTH - 1));

`ifdef SEQ_MULT_SIGNED_EN
    logic w_a_neg;
    logic w_b_neg;
    logic r_neg;

    // Magnitude of the most negative operand is 2^(WIDTH-1), which still fits
    // in WIDTH unsigned bits, so the run itself stays a plain unsigned multiply.
    assign w_a_neg  = is_signed && a[WIDTH-1];
    assign w_b_neg  = is_signed && b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;
    assign w_result = r_neg ? (~w_acc_next + 1'b1) : w_acc_next;

    // Remember whether the final product needs negating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= w_a_neg ^ w_b_neg;
        end
    end
`else
    assign w_a_mag  = a;
    assign w_b_mag  = b;
    assign w_result = w_acc_next;
`endif

    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit is set, keep the carry, then shift right by one.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and Moore status outputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) w_state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                ready        = 1'b1;
                done         = 1'b1;
                w_state_next = start ? S_RUN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: load operands on accept, step once per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
            r_mcand <= w_a_mag;
            r_count <= '0;
        end else if (r_state == S_RUN) begin
            r_acc   <= w_acc_next;
            r_count <= r_count + CW'(1);
        end
    end

    // Result register: written only on the final RUN step, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
        end else if (r_state == S_RUN && w_last) begin
            product <= w_result;
        end
    end

endmodule
